// File: rtl/mod_mult.sv
// rtl/mod_mult.sv - modular multiplier, (a*b) mod n by interleaved MSB-first shift-add
// One multiplier bit per clock; result registered on the last CALC edge.
module mod_mult #(
  parameter int ARQ = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ARQ*2-1:0]   a,
  input  logic [ARQ*2-1:0]   b,
  input  logic [ARQ*2-1:0]   modulo,
  output logic               busy,
  output logic               finish,
  output logic [ARQ*2-1:0]   result
);

  localparam int W  = ARQ * 2;
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          r_state;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_n;
  logic [W+1:0]    r_p;
  logic [CW-1:0]   r_cnt;

  logic [W+1:0]    w_n;
  logic [W+1:0]    w_addend;
  logic [W+1:0]    w_sum;
  logic [W+1:0]    w_sub1;
  logic [W+1:0]    w_sub2;
  logic [W+1:0]    w_next;

  // 2P + a < 3n when P < n and a < n, so two conditional subtractions suffice.
  always_comb begin
    w_n      = {2'b00, r_n};
    w_addend = r_b[r_cnt] ? {2'b00, r_a} : '0;
    w_sum    = (r_p << 1) + w_addend;
    w_sub1   = (w_sum  >= w_n) ? (w_sum  - w_n) : w_sum;
    w_sub2   = (w_sub1 >= w_n) ? (w_sub1 - w_n) : w_sub1;
    w_next   = (r_n == '0) ? '0 : w_sub2;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_n     <= '0;
      r_p     <= '0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      finish  <= 1'b0;
      result  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_n     <= modulo;
            r_p     <= '0;
            r_cnt   <= CW'(W - 1);
            busy    <= 1'b1;
            r_state <= CALC;
          end
        end
        CALC: begin
          r_p <= w_next;
          if (r_cnt == '0) begin
            result  <= w_next[W-1:0];
            busy    <= 1'b0;
            finish  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        DONE: begin
          finish  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          finish  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mod_mult.sv
// tb/tb_mod_mult.sv - randomized self-checking bench for mod_mult against a 64-bit arithmetic model
module tb_mod_mult;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] modulo;
  logic        busy;
  logic        finish;
  logic [31:0] result;

  int n_checks = 0;
  int n_errors = 0;

  mod_mult #(.ARQ(16)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .a      (a),
    .b      (b),
    .modulo (modulo),
    .busy   (busy),
    .finish (finish),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] ma, input logic [31:0] mb, input logic [31:0] mn);
    logic [63:0] prod;
    if (mn == 32'd0) return 32'd0;
    prod = {32'd0, ma} * {32'd0, mb};
    return 32'(prod % {32'd0, mn});
  endfunction

  task automatic do_op(input logic [31:0] ta, input logic [31:0] tb, input logic [31:0] tn, input int repulse);
    logic [31:0] exp;
    int lat;
    int gaps;
    int extra;
    bit done;
    exp = model(ta, tb, tn);
    @(negedge clk);
    a = ta; b = tb; modulo = tn; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; modulo = $urandom;
    check("busy_rise", busy, 1);
    lat = 0; gaps = 0; done = 0;
    while (!done && lat < 40) begin
      if (repulse != 0 && lat == repulse) begin
        start = 1'b1; a = $urandom; b = $urandom; modulo = $urandom_range(2, 1000);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
      if (finish) done = 1;
      else if (!busy) gaps++;
    end
    start = 1'b0;
    check("latency", lat, 32);
    check("busy_hold", gaps, 0);
    check("result", result, exp);
    check("busy_done", busy, 0);
    extra = 0;
    for (int i = 0; i < ((repulse != 0) ? 40 : 6); i++) begin
      @(posedge clk); #1;
      if (finish) extra++;
    end
    check("finish_once", extra, 0);
    check("result_hold", result, exp);
  endtask

  initial begin
    int fin[3];
    int nf;
    logic [31:0] rn;
    reset = 1'b0; start = 1'b0; a = '0; b = '0; modulo = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_finish", finish, 0);
    check("rst_result", result, 0);
    @(negedge clk);
    reset = 1'b1;

    do_op(32'd255, 32'd255, 32'd1927, 0);
    check("const_1434", result, 32'd1434);
    do_op(32'd1926, 32'd1926, 32'd1927, 0);
    check("const_1", result, 32'd1);
    do_op(32'd0, 32'd1234, 32'd1927, 0);
    do_op(32'hFFFFFFFA, 32'hFFFFFFFA, 32'hFFFFFFFB, 0);
    check("full_width", result, 32'd1);
    do_op(32'd255, 32'd255, 32'd1927, 10);

    for (int i = 0; i < 20; i++) begin
      rn = (i % 2 == 0) ? ($urandom | 32'h1) : $urandom_range(1, 5000);
      do_op($urandom % rn, $urandom % rn, rn, 0);
    end
    do_op(32'd123, 32'd456, 32'd1000, 0);

    @(negedge clk);
    a = 32'd255; b = 32'd255; modulo = 32'd1927; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("async_busy", busy, 0);
    check("async_finish", finish, 0);
    check("async_result", result, 0);
    nf = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (finish || busy) nf++;
    end
    check("rst_hold_quiet", nf, 0);
    @(negedge clk);
    reset = 1'b1;
    do_op(32'd255, 32'd255, 32'd1927, 0);

    @(negedge clk);
    a = $urandom; b = $urandom; modulo = 32'd0; start = 1'b1;
    fin[0] = -1; fin[1] = -1; fin[2] = -1; nf = 0;
    for (int c = 0; c <= 110; c++) begin
      @(posedge clk); #1;
      if (finish) begin
        check("b2b_result", result, 0);
        check("b2b_busy", busy, 0);
        if (nf < 3) fin[nf] = c;
        nf++;
      end
    end
    start = 1'b0;
    check("b2b_count", nf, 3);
    check("b2b_first", fin[0], 32);
    check("b2b_second", fin[1], 66);
    check("b2b_third", fin[2], 100);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mod_mult.md
MOD_MULT -- requirements
Module: mod_mult

Interface
REQ-001 The block SHALL have parameter ARQ, default 16, giving an operand width of W = ARQ*2 bits.
REQ-002 Port clk SHALL be an input, 1 bit wide, and serve as the single clock; all state SHALL update on the rising edge.
REQ-003 Port reset SHALL be an input, 1 bit wide, and act as the asynchronous, active-low reset.
REQ-004 Port start SHALL be an input, 1 bit wide, requesting a new multiplication.
REQ-005 Port a SHALL be an input, W bits wide, carrying the multiplicand.
REQ-006 Port b SHALL be an input, W bits wide, carrying the multiplier.
REQ-007 Port modulo SHALL be an input, W bits wide, carrying the modulus n.
REQ-008 Port busy SHALL be an output, 1 bit wide, high while a computation is in progress.
REQ-009 Port finish SHALL be an output, 1 bit wide, and pulse high for one cycle when result is valid.
REQ-010 Port result SHALL be an output, W bits wide, carrying (a*b) mod n.

Function
REQ-011 The block SHALL compute result = (a*b) mod modulo using interleaved MSB-first shift-add: P=0; for i=W-1..0: P=2P+(b[i]?a:0); while P>=n subtract n (at most two subtractions per iteration).
REQ-012 The internal accumulator and compare/subtract path SHALL be W+2 bits wide, so no intermediate value overflows.
REQ-013 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-014 In IDLE, start=1 at a rising edge SHALL latch a, b and modulo into internal registers, clear P, load the bit counter with W-1 and move the FSM to CALC.
REQ-015 In IDLE with start=0, the FSM SHALL stay in IDLE and all outputs SHALL hold their values.
REQ-016 In CALC, the block SHALL perform one iteration per edge, using the latched operands only; input changes after the latch edge SHALL have no effect.
REQ-017 When the CALC iteration with counter=0 completes, the FSM SHALL move to DONE and register the final P into result on that same edge.
REQ-018 DONE SHALL last exactly one cycle and then return unconditionally to IDLE.
REQ-019 busy SHALL be 1 exactly while the FSM is in CALC.
REQ-020 finish SHALL be 1 exactly while the FSM is in DONE.
REQ-021 Latency SHALL be fixed: finish SHALL rise W edges after the edge that sampled start (32 for ARQ=16), independent of operand values.
REQ-022 start asserted in CALC or DONE SHALL be ignored; it is not queued.
REQ-023 start held high continuously SHALL launch a new operation on each IDLE edge, giving back-to-back runs of W+2 cycles each.
REQ-024 result SHALL hold its value from one completion until the next completion or reset.
REQ-025 If the latched modulo is 0, the block SHALL produce result=0 with the normal latency and handshake.
REQ-026 The caller guarantees a<modulo and b<modulo; if violated, result is don't-care but latency and handshake SHALL be unchanged.

Reset
REQ-027 When reset=0, the block SHALL immediately, without waiting for a clock edge, force state=IDLE, busy=0, finish=0 and result=0, and clear the accumulator, counter and latched operands.
REQ-028 A reset asserted in CALC or DONE SHALL abort the operation with no finish pulse; the first start after reset deassertion SHALL run normally.

Verification
REQ-029 ARQ=16, a=255, b=255, modulo=1927, start for one cycle -> busy high for 32 cycles, then finish for one cycle with result=1434.
REQ-030 a=1926, b=1926, modulo=1927 -> result=1; a=0, b=1234, modulo=1927 -> result=0; both with 32-cycle latency.
REQ-031 Full-width case: modulo=32'hFFFFFFFB, a=b=32'hFFFFFFFA -> result=1, checking the W+2-bit path.
REQ-032 start re-pulsed at CALC cycle 10 with different operands -> ignored; the original result is produced and finish pulses exactly once.
REQ-033 reset driven low at CALC cycle 15 -> busy, finish and result go to 0 at once with no clock edge; after release, a start with 255, 255, 1927 -> 1434 after 32 cycles.
REQ-034 start held high with modulo=0 -> back-to-back runs every 34 cycles, each ending with finish=1 and result=0.
